fifo_pkt_reader: RTL

Consumer for the read side of the `fifoif` FIFO. It pops a header word giving a payload length, then pops that many payload words and presents them on a registered valid/ready output stream, with `out_last` on the final word. It sits between the FIFO's `pull`/`dataout`/`empty` signals and a downstream packet sink. It also reports completed packets and rejected headers.

---
 rtl/fifo_pkt_reader_if.sv | 42 ++++
 rtl/fifo_pkt_reader.sv | 105 ++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader_if.sv
// Read-side FIFO pop handshake plus packet output stream
// for fifo_pkt_reader.
interface fifo_pkt_reader_if #(
  parameter int busw = 32
);
  logic            en;
  logic            empty;
  logic [busw-1:0] dataout;
  logic            pull;
  logic            out_valid;
  logic [busw-1:0] out_data;
  logic            out_last;
  logic            out_ready;
  logic            err_len;
  logic [15:0]     pkt_cnt;

  modport slave (
    input  en,
    input  empty,
    input  dataout,
    input  out_ready,
    output pull,
    output out_valid,
    output out_data,
    output out_last,
    output err_len,
    output pkt_cnt
  );

  modport master (
    output en,
    output empty,
    output dataout,
    output out_ready,
    input  pull,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  err_len,
    input  pkt_cnt
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed packets from a FIFO and streams the
// payload out on a registered valid/ready port.
module fifo_pkt_reader #(
  parameter int busw   = 32,
  parameter int maxlen = 16
) (
  input  logic         clk,
  input  logic         rst,
  fifo_pkt_reader_if.slave bus
);

  typedef enum logic {
    HDR,
    PAY
  } state_e;

  localparam logic [15:0] MaxLen = 16'(maxlen);

  state_e          state_q, state_d;
  logic [15:0]     rem_q, rem_d;
  logic            vld_q, vld_d;
  logic            last_q, last_d;
  logic [busw-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [15:0] len;
  logic        pull;
  logic        accept;

  assign len    = bus.dataout[15:0];
  assign accept = vld_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q + {15'd0, accept & last_q};
    pull    = 1'b0;

    // An accepted word leaves unless a payload pull refills it.
    if (accept) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    unique case (state_q)
      HDR: begin
        pull = bus.en & ~bus.empty & ~rst;
        if (pull) begin
          if (len > MaxLen) begin
            err_d = 1'b1;
          end else if (len != 16'd0) begin
            rem_d   = len;
            state_d = PAY;
          end
        end
      end
      PAY: begin
        pull = ~bus.empty & (~vld_q | bus.out_ready) & ~rst;
        if (pull) begin
          data_d = bus.dataout;
          vld_d  = 1'b1;
          last_d = (rem_q == 16'd1);
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = HDR;
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pull      = pull;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.err_len   = err_q;
  assign bus.pkt_cnt   = cnt_q;

endmodule
